// File: rtl/audio_mixer_pkg.sv
// Shared types and sizing helpers for the time-multiplexed stereo mixer.
package audio_mixer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2,
        OUT   = 2'd3
    } state_e;

    function automatic int gain_unity(input int gain_width);
        return 1 << (gain_width - 1);
    endfunction

    // One guard bit on top of the worst-case sum keeps the signed accumulator from wrapping.
    function automatic int acc_width(input int in_width, input int gain_width, input int num_ch);
        return in_width + gain_width + $clog2(num_ch) + 1;
    endfunction

endpackage

// File: rtl/audio_mixer_sat.sv
// Combinational gain-normalising shift plus clamp to the output sample range.
module audio_mixer_sat #(
    parameter int ACC_WIDTH = 27,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 7,
    parameter int SIGNED    = 0
) (
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    output logic [OUT_WIDTH-1:0]        sample_o,
    output logic                        clip_o
);

    localparam logic signed [ACC_WIDTH-1:0] MAX_V = (SIGNED != 0)
        ? {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}}
        : {{(ACC_WIDTH-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_V = (SIGNED != 0) ? ~MAX_V : '0;

    logic signed [ACC_WIDTH-1:0] shifted;

    assign shifted = acc_i >>> SHIFT;

    always_comb begin
        sample_o = shifted[OUT_WIDTH-1:0];
        clip_o   = 1'b0;
        if (shifted > MAX_V) begin
            sample_o = MAX_V[OUT_WIDTH-1:0];
            clip_o   = 1'b1;
        end else if (shifted < MIN_V) begin
            sample_o = MIN_V[OUT_WIDTH-1:0];
            clip_o   = 1'b1;
        end
    end

endmodule

// File: rtl/audio_mixer.sv
// N-channel stereo mixer: one channel multiply-accumulate per clock after a sample strobe,
// saturating output with sticky clip and overrun flags.
//   state | meaning
//   IDLE  | waiting for sample_strobe_i
//   ACCUM | one channel MAC per cycle into both accumulators
//   SAT   | shift/clamp accumulators, load outputs
//   OUT   | outputs valid for this cycle
module audio_mixer
    import audio_mixer_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int IN_WIDTH   = 16,
    parameter int GAIN_WIDTH = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int SIGNED_IN  = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 sample_strobe_i,
    input  logic [NUM_CH-1:0][IN_WIDTH-1:0]      ch_data_i,
    input  logic [NUM_CH-1:0][GAIN_WIDTH-1:0]    ch_gain_l_i,
    input  logic [NUM_CH-1:0][GAIN_WIDTH-1:0]    ch_gain_r_i,
    input  logic [NUM_CH-1:0]                    ch_mute_i,
    input  logic                                 clip_clear_i,
    output logic [OUT_WIDTH-1:0]                 audio_l_o,
    output logic [OUT_WIDTH-1:0]                 audio_r_o,
    output logic                                 valid_o,
    output logic                                 busy_o,
    output logic                                 clip_l_o,
    output logic                                 clip_r_o,
    output logic                                 overrun_o
);

    localparam int AW    = acc_width(IN_WIDTH, GAIN_WIDTH, NUM_CH);
    localparam int IW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SHIFT = $clog2(gain_unity(GAIN_WIDTH));

    state_e                              state_q;
    logic [IW-1:0]                       idx_q;
    logic [NUM_CH-1:0][IN_WIDTH-1:0]     data_q;
    logic [NUM_CH-1:0][GAIN_WIDTH-1:0]   gain_l_q;
    logic [NUM_CH-1:0][GAIN_WIDTH-1:0]   gain_r_q;
    logic [NUM_CH-1:0]                   mute_q;
    logic signed [AW-1:0]                acc_l_q;
    logic signed [AW-1:0]                acc_r_q;
    logic [OUT_WIDTH-1:0]                audio_l_q;
    logic [OUT_WIDTH-1:0]                audio_r_q;
    logic                                valid_q;
    logic                                clip_l_q;
    logic                                clip_r_q;
    logic                                overrun_q;

    logic [IN_WIDTH-1:0]                 cur_data;
    logic signed [AW-1:0]                data_ext;
    logic signed [AW-1:0]                gain_l_ext;
    logic signed [AW-1:0]                gain_r_ext;
    logic signed [AW-1:0]                acc_l_d;
    logic signed [AW-1:0]                acc_r_d;
    logic [OUT_WIDTH-1:0]                sat_l;
    logic [OUT_WIDTH-1:0]                sat_r;
    logic                                sat_clip_l;
    logic                                sat_clip_r;
    logic                                clip_set_l;
    logic                                clip_set_r;
    logic                                overrun_set;

    // Gains are unsigned, so they are always zero-extended before the signed multiply.
    always_comb begin
        cur_data   = data_q[idx_q];
        data_ext   = {{(AW-IN_WIDTH){1'b0}}, cur_data};
        if (SIGNED_IN != 0) begin
            data_ext = {{(AW-IN_WIDTH){cur_data[IN_WIDTH-1]}}, cur_data};
        end
        gain_l_ext = {{(AW-GAIN_WIDTH){1'b0}}, gain_l_q[idx_q]};
        gain_r_ext = {{(AW-GAIN_WIDTH){1'b0}}, gain_r_q[idx_q]};
        acc_l_d    = acc_l_q + (mute_q[idx_q] ? '0 : data_ext * gain_l_ext);
        acc_r_d    = acc_r_q + (mute_q[idx_q] ? '0 : data_ext * gain_r_ext);
    end

    audio_mixer_sat #(
        .ACC_WIDTH (AW),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT),
        .SIGNED    (SIGNED_IN)
    ) u_sat_l (
        .acc_i    (acc_l_q),
        .sample_o (sat_l),
        .clip_o   (sat_clip_l)
    );

    audio_mixer_sat #(
        .ACC_WIDTH (AW),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT),
        .SIGNED    (SIGNED_IN)
    ) u_sat_r (
        .acc_i    (acc_r_q),
        .sample_o (sat_r),
        .clip_o   (sat_clip_r)
    );

    assign clip_set_l  = (state_q == SAT) && sat_clip_l;
    assign clip_set_r  = (state_q == SAT) && sat_clip_r;
    assign overrun_set = sample_strobe_i && (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            gain_l_q  <= '0;
            gain_r_q  <= '0;
            mute_q    <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            audio_l_q <= '0;
            audio_r_q <= '0;
            valid_q   <= 1'b0;
            clip_l_q  <= 1'b0;
            clip_r_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            // A new set in the same cycle as a clear must survive.
            clip_l_q  <= (clip_l_q & ~clip_clear_i) | clip_set_l;
            clip_r_q  <= (clip_r_q & ~clip_clear_i) | clip_set_r;
            overrun_q <= (overrun_q & ~clip_clear_i) | overrun_set;
            case (state_q)
                IDLE: begin
                    if (sample_strobe_i) begin
                        data_q   <= ch_data_i;
                        gain_l_q <= ch_gain_l_i;
                        gain_r_q <= ch_gain_r_i;
                        mute_q   <= ch_mute_i;
                        acc_l_q  <= '0;
                        acc_r_q  <= '0;
                        idx_q    <= '0;
                        state_q  <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_l_q <= acc_l_d;
                    acc_r_q <= acc_r_d;
                    idx_q   <= idx_q + IW'(1);
                    if (idx_q == IW'(NUM_CH - 1)) begin
                        state_q <= SAT;
                    end
                end
                SAT: begin
                    audio_l_q <= sat_l;
                    audio_r_q <= sat_r;
                    valid_q   <= 1'b1;
                    state_q   <= OUT;
                end
                OUT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign audio_l_o = audio_l_q;
    assign audio_r_o = audio_r_q;
    assign valid_o   = valid_q;
    assign busy_o    = (state_q != IDLE);
    assign clip_l_o  = clip_l_q;
    assign clip_r_o  = clip_r_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_audio_mixer.sv
// Bench for audio_mixer: unsigned and signed instances driven in lockstep, checked against
// an integer-arithmetic mix model.
module tb_audio_mixer;

    logic clk = 1'b0;
    logic reset;
    logic strobe;
    logic [3:0][15:0] data;
    logic [3:0][7:0]  gl;
    logic [3:0][7:0]  gr;
    logic [3:0]       mute;
    logic             clip_clear;

    logic [15:0] l_o [2];
    logic [15:0] r_o [2];
    logic        valid_o [2];
    logic        busy_o [2];
    logic        clip_l_o [2];
    logic        clip_r_o [2];
    logic        ovr_o [2];

    bit m_clip_l [2];
    bit m_clip_r [2];
    bit m_ovr [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    audio_mixer #(.NUM_CH(4), .IN_WIDTH(16), .GAIN_WIDTH(8), .OUT_WIDTH(16), .SIGNED_IN(0)) dut_u (
        .clk(clk), .reset(reset), .sample_strobe_i(strobe), .ch_data_i(data),
        .ch_gain_l_i(gl), .ch_gain_r_i(gr), .ch_mute_i(mute), .clip_clear_i(clip_clear),
        .audio_l_o(l_o[0]), .audio_r_o(r_o[0]), .valid_o(valid_o[0]), .busy_o(busy_o[0]),
        .clip_l_o(clip_l_o[0]), .clip_r_o(clip_r_o[0]), .overrun_o(ovr_o[0]));

    audio_mixer #(.NUM_CH(4), .IN_WIDTH(16), .GAIN_WIDTH(8), .OUT_WIDTH(16), .SIGNED_IN(1)) dut_s (
        .clk(clk), .reset(reset), .sample_strobe_i(strobe), .ch_data_i(data),
        .ch_gain_l_i(gl), .ch_gain_r_i(gr), .ch_mute_i(mute), .clip_clear_i(clip_clear),
        .audio_l_o(l_o[1]), .audio_r_o(r_o[1]), .valid_o(valid_o[1]), .busy_o(busy_o[1]),
        .clip_l_o(clip_l_o[1]), .clip_r_o(clip_r_o[1]), .overrun_o(ovr_o[1]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mix model: sum of unmuted data*gain, floor-divide by unity gain, clamp to output range.
    function automatic void model(input int sgn, input bit right, output logic [15:0] y, output bit clip);
        longint s = 0;
        longint hi = (sgn != 0) ? 32767 : 65535;
        longint lo = (sgn != 0) ? -32768 : 0;
        longint d;
        for (int i = 0; i < 4; i++) begin
            d = (sgn != 0) ? longint'($signed(data[i])) : longint'(data[i]);
            if (!mute[i]) s += d * longint'(right ? gr[i] : gl[i]);
        end
        s = s >>> 7;
        clip = 1'b0;
        if (s > hi) begin
            s = hi;
            clip = 1'b1;
        end else if (s < lo) begin
            s = lo;
            clip = 1'b1;
        end
        y = s[15:0];
    endfunction

    task automatic check_flags(input string tag);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("%s[%0d] clip_l", tag, s), 32'(clip_l_o[s]), 32'(m_clip_l[s]));
            check($sformatf("%s[%0d] clip_r", tag, s), 32'(clip_r_o[s]), 32'(m_clip_r[s]));
            check($sformatf("%s[%0d] overrun", tag, s), 32'(ovr_o[s]), 32'(m_ovr[s]));
        end
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 3))
                0:       data[i] = 16'hFFFF;
                1:       data[i] = 16'h8000;
                default: data[i] = 16'($urandom);
            endcase
            gl[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            gr[i] = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
        end
        mute = 4'($urandom);
    endtask

    task automatic run_mix(input string tag, input bit scramble);
        logic [15:0] el [2];
        logic [15:0] er [2];
        bit cl [2];
        bit cr [2];
        int lat;
        for (int s = 0; s < 2; s++) begin
            model(s, 1'b0, el[s], cl[s]);
            model(s, 1'b1, er[s], cr[s]);
        end
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        if (scramble) randomize_inputs();
        lat = 1;
        while (valid_o[0] !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd6);
        for (int s = 0; s < 2; s++) begin
            m_clip_l[s] |= cl[s];
            m_clip_r[s] |= cr[s];
            check($sformatf("%s[%0d] valid", tag, s), 32'(valid_o[s]), 32'd1);
            check($sformatf("%s[%0d] L", tag, s), 32'(l_o[s]), 32'(el[s]));
            check($sformatf("%s[%0d] R", tag, s), 32'(r_o[s]), 32'(er[s]));
        end
        check_flags(tag);
        tick();
        for (int s = 0; s < 2; s++) begin
            check($sformatf("%s[%0d] valid_end", tag, s), 32'(valid_o[s]), 32'd0);
            check($sformatf("%s[%0d] busy_end", tag, s), 32'(busy_o[s]), 32'd0);
        end
    endtask

    task automatic clear_flags();
        clip_clear = 1'b1;
        tick();
        clip_clear = 1'b0;
        for (int s = 0; s < 2; s++) begin
            m_clip_l[s] = 1'b0;
            m_clip_r[s] = 1'b0;
            m_ovr[s]    = 1'b0;
        end
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen = 0;
        for (int c = 0; c < cycles; c++) begin
            if (valid_o[0] || valid_o[1]) seen++;
            tick();
        end
        check({tag, " no valid"}, 32'(seen), 32'd0);
    endtask

    task automatic set_all(input logic [15:0] d, input logic [7:0] g);
        for (int i = 0; i < 4; i++) begin
            data[i] = d;
            gl[i]   = g;
            gr[i]   = g;
        end
        mute = '0;
    endtask

    initial begin
        logic [15:0] el [2];
        logic [15:0] er [2];
        bit cl [2];
        bit cr [2];
        int nvalid;
        int first;
        reset = 1'b1;
        strobe = 1'b0;
        clip_clear = 1'b0;
        set_all(16'h0, 8'h0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        for (int s = 0; s < 2; s++) begin
            check($sformatf("rst[%0d] L", s), 32'(l_o[s]), 32'd0);
            check($sformatf("rst[%0d] R", s), 32'(r_o[s]), 32'd0);
            check($sformatf("rst[%0d] valid", s), 32'(valid_o[s]), 32'd0);
            check($sformatf("rst[%0d] busy", s), 32'(busy_o[s]), 32'd0);
        end
        check_flags("rst");
        expect_quiet("idle", 8);

        set_all(16'h0, 8'd128);
        data[0] = 16'h1000;
        run_mix("unity", 1'b0);
        check("unity L abs", 32'(l_o[0]), 32'h1000);

        set_all(16'h0, 8'd0);
        data[1] = 16'h2000;
        gl[1] = 8'd255;
        run_mix("pan", 1'b0);
        mute[1] = 1'b1;
        run_mix("mute", 1'b0);

        set_all(16'hFFFF, 8'd128);
        run_mix("full", 1'b0);
        set_all(16'h0, 8'd128);
        data[0] = 16'h1000;
        run_mix("clean", 1'b0);
        clear_flags();
        check_flags("cleared");

        // Second strobe two cycles into a mix: ignored, flagged as overrun.
        set_all(16'h0, 8'd128);
        data[2] = 16'h0400;
        gl[2] = 8'd64;
        for (int s = 0; s < 2; s++) begin
            model(s, 1'b0, el[s], cl[s]);
            model(s, 1'b1, er[s], cr[s]);
        end
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        set_all(16'h7777, 8'd200);
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        nvalid = 0;
        first = 0;
        for (int c = 3; c < 15; c++) begin
            if (valid_o[0]) begin
                nvalid++;
                if (first == 0) begin
                    first = c;
                    for (int s = 0; s < 2; s++) begin
                        check($sformatf("ovr[%0d] L", s), 32'(l_o[s]), 32'(el[s]));
                        check($sformatf("ovr[%0d] R", s), 32'(r_o[s]), 32'(er[s]));
                    end
                end
            end
            tick();
        end
        check("ovr valid count", 32'(nvalid), 32'd1);
        check("ovr latency", 32'(first), 32'd6);
        m_ovr[0] = 1'b1;
        m_ovr[1] = 1'b1;
        check_flags("ovr");
        clear_flags();

        set_all(16'hC000, 8'd128);
        data[3] = 16'h0;
        run_mix("neg", 1'b0);
        check("neg L abs", 32'(l_o[1]), 32'h8000);
        check("neg clip abs", 32'(clip_l_o[1]), 32'd1);

        // Reset three cycles into a mix.
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            check($sformatf("midrst[%0d] busy", s), 32'(busy_o[s]), 32'd0);
            check($sformatf("midrst[%0d] L", s), 32'(l_o[s]), 32'd0);
            m_clip_l[s] = 1'b0;
            m_clip_r[s] = 1'b0;
            m_ovr[s]    = 1'b0;
        end
        check_flags("midrst");
        expect_quiet("midrst", 10);

        for (int k = 0; k < 30; k++) begin
            randomize_inputs();
            run_mix($sformatf("rnd%0d", k), 1'b1);
            if ($urandom_range(0, 4) == 0) clear_flags();
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
